// File: rtl/action_initiator.sv
// Requester side of the home-action 4-phase handshake: turns command pulses and
// stat-driven auto requests into held doEat/doSleep levels, with one-deep buffering and timeout abort.
module action_initiator #(
    parameter int unsigned TIMEOUT = 300_000_000,
    parameter logic [7:0]  THRESH  = 8'd200,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eatReq,
    input  logic             sleepReq,
    input  logic             autoEn,
    input  logic [7:0]       hunger,
    input  logic [7:0]       sleepiness,
    input  logic             done,
    output logic             doEat,
    output logic             doSleep,
    output logic             busy,
    output logic [CNT_W-1:0] actionCount,
    output logic             timeoutErr
);

    localparam int unsigned     TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ_EAT,
        REQ_SLEEP,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic             pend_eat_q, pend_eat_d;
    logic             pend_sleep_q, pend_sleep_d;
    logic [TMR_W-1:0] tmr_q;
    logic             issue_pend;
    logic             complete;
    logic             expire;
    logic             in_req;

    assign in_req = (state_q == REQ_EAT) || (state_q == REQ_SLEEP);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        issue_pend = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_eat_q) begin
                    state_d    = REQ_EAT;
                    issue_pend = 1'b1;
                end else if (pend_sleep_q) begin
                    state_d    = REQ_SLEEP;
                    issue_pend = 1'b1;
                end else if (eatReq) begin
                    state_d = REQ_EAT;
                end else if (sleepReq) begin
                    state_d = REQ_SLEEP;
                end else if (autoEn && (hunger >= THRESH)) begin
                    state_d = REQ_EAT;
                end else if (autoEn && (sleepiness >= THRESH)) begin
                    state_d = REQ_SLEEP;
                end
            end
            REQ_EAT, REQ_SLEEP: begin
                // Completion wins over a timeout landing on the same cycle.
                if (done) begin
                    state_d  = RELEASE;
                    complete = 1'b1;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = RELEASE;
                    expire  = 1'b1;
                end
            end
            RELEASE: begin
                if (!done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_eat_d   = pend_eat_q;
        pend_sleep_d = pend_sleep_q;
        if (state_q == IDLE) begin
            if (issue_pend) begin
                pend_eat_d   = 1'b0;
                pend_sleep_d = 1'b0;
            end else if (eatReq && sleepReq) begin
                pend_eat_d   = 1'b0;
                pend_sleep_d = 1'b1;
            end
        end else begin
            // A request for the action already in flight is dropped.
            if (eatReq && (state_q != REQ_EAT)) begin
                pend_eat_d   = 1'b1;
                pend_sleep_d = 1'b0;
            end else if (sleepReq && (state_q != REQ_SLEEP)) begin
                pend_eat_d   = 1'b0;
                pend_sleep_d = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_eat_q   <= 1'b0;
            pend_sleep_q <= 1'b0;
            tmr_q        <= '0;
            doEat        <= 1'b0;
            doSleep      <= 1'b0;
            busy         <= 1'b0;
            actionCount  <= '0;
            timeoutErr   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_eat_q   <= pend_eat_d;
            pend_sleep_q <= pend_sleep_d;
            tmr_q        <= in_req ? tmr_q + TMR_W'(1) : '0;
            doEat        <= (state_d == REQ_EAT);
            doSleep      <= (state_d == REQ_SLEEP);
            busy         <= (state_d != IDLE);
            timeoutErr   <= expire;
            if (complete && (actionCount != {CNT_W{1'b1}})) begin
                actionCount <= actionCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_action_initiator.sv
// Directed bench for action_initiator: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_action_initiator;

    localparam int         TIMEOUT = 20;
    localparam logic [7:0] THRESH  = 8'd200;
    localparam int         CNT_W   = 8;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             eatReq = 1'b0;
    logic             sleepReq = 1'b0;
    logic             autoEn = 1'b0;
    logic [7:0]       hunger = 8'd0;
    logic [7:0]       sleepiness = 8'd0;
    logic             done = 1'b0;
    logic             doEat;
    logic             doSleep;
    logic             busy;
    logic [CNT_W-1:0] actionCount;
    logic             timeoutErr;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    action_initiator #(
        .TIMEOUT(TIMEOUT),
        .THRESH (THRESH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .eatReq     (eatReq),
        .sleepReq   (sleepReq),
        .autoEn     (autoEn),
        .hunger     (hunger),
        .sleepiness (sleepiness),
        .done       (done),
        .doEat      (doEat),
        .doSleep    (doSleep),
        .busy       (busy),
        .actionCount(actionCount),
        .timeoutErr (timeoutErr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: which action is being requested, whether we are waiting for done to
    // drop, how long the request has waited, and a one-entry pending queue.
    typedef enum int {NONE, EAT, SLEEP} act_e;
    act_e m_active    = NONE;
    bit   m_releasing = 1'b0;
    int   m_age       = 0;
    int   m_count     = 0;
    bit   m_terr      = 1'b0;
    act_e m_pending[$];

    task automatic m_capture();
        if (eatReq && m_active != EAT) begin
            m_pending.delete();
            m_pending.push_back(EAT);
        end else if (sleepReq && m_active != SLEEP) begin
            m_pending.delete();
            m_pending.push_back(SLEEP);
        end
    endtask

    task automatic m_step();
        if (reset) begin
            m_active    = NONE;
            m_releasing = 1'b0;
            m_age       = 0;
            m_count     = 0;
            m_terr      = 1'b0;
            m_pending.delete();
        end else begin
            m_terr = 1'b0;
            if (m_releasing) begin
                m_capture();
                if (!done) m_releasing = 1'b0;
            end else if (m_active != NONE) begin
                m_capture();
                if (done) begin
                    m_count     = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
                    m_active    = NONE;
                    m_releasing = 1'b1;
                end else if (m_age == TIMEOUT - 1) begin
                    m_terr      = 1'b1;
                    m_active    = NONE;
                    m_releasing = 1'b1;
                end else begin
                    m_age++;
                end
            end else begin
                m_age = 0;
                if (m_pending.size() > 0) begin
                    m_active = m_pending.pop_front();
                end else if (eatReq) begin
                    m_active = EAT;
                    if (sleepReq) m_pending.push_back(SLEEP);
                end else if (sleepReq) begin
                    m_active = SLEEP;
                end else if (autoEn && hunger >= THRESH) begin
                    m_active = EAT;
                end else if (autoEn && sleepiness >= THRESH) begin
                    m_active = SLEEP;
                end
            end
        end
    endtask

    always @(posedge clk) m_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_doEat",       doEat,           m_active == EAT);
            check("model_doSleep",     doSleep,         m_active == SLEEP);
            check("model_busy",        busy,            (m_active != NONE) || m_releasing);
            check("model_actionCount", actionCount,     m_count);
            check("model_timeoutErr",  timeoutErr,      m_terr);
            check("exclusive_req",     doEat & doSleep, 1'b0);
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        eatReq     = 1'b0;
        sleepReq   = 1'b0;
        autoEn     = 1'b0;
        hunger     = 8'd0;
        sleepiness = 8'd0;
        done       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic handshake();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;
        check("reset_doEat",  doEat,       1'b0);
        check("reset_busy",   busy,        1'b0);
        check("reset_count",  actionCount, 8'd0);

        // 1. single eat with exact cycle timing
        eatReq = 1'b1;
        tick();
        eatReq = 1'b0;
        check("t1_doEat_c1", doEat, 1'b1);
        check("t1_busy_c1",  busy,  1'b1);
        repeat (7) tick();
        done = 1'b1;
        tick();
        check("t1_doEat_c9", doEat,       1'b0);
        check("t1_count_c9", actionCount, 8'd1);
        tick();
        check("t1_busy_c10", busy, 1'b1);
        done = 1'b0;
        tick();
        check("t1_busy_c11", busy, 1'b0);

        // 2. simultaneous eat+sleep: eat first, buffered sleep afterwards
        do_reset();
        eatReq   = 1'b1;
        sleepReq = 1'b1;
        tick();
        eatReq   = 1'b0;
        sleepReq = 1'b0;
        check("t2_doEat",   doEat,   1'b1);
        check("t2_doSleep", doSleep, 1'b0);
        tick();
        handshake();
        check("t2_idle_busy", busy, 1'b0);
        tick();
        check("t2_doSleep_after", doSleep, 1'b1);
        handshake();
        check("t2_count", actionCount, 8'd2);

        // 3. timeout on sleep request
        do_reset();
        sleepReq = 1'b1;
        tick();
        sleepReq = 1'b0;
        repeat (19) tick();
        check("t3_doSleep_last", doSleep,    1'b1);
        check("t3_noerr_yet",    timeoutErr, 1'b0);
        tick();
        check("t3_doSleep_drop", doSleep,     1'b0);
        check("t3_timeoutErr",   timeoutErr,  1'b1);
        check("t3_count",        actionCount, 8'd0);
        tick();
        check("t3_timeoutErr_once", timeoutErr, 1'b0);
        check("t3_idle",            busy,       1'b0);

        // 4. auto mode
        do_reset();
        autoEn     = 1'b1;
        hunger     = 8'd200;
        sleepiness = 8'd0;
        tick();
        check("t4_auto_eat", doEat, 1'b1);
        hunger     = 8'd199;
        sleepiness = 8'd250;
        tick();
        check("t4_inflight", doEat, 1'b1);
        handshake();
        tick();
        check("t4_auto_sleep", doSleep, 1'b1);
        hunger     = 8'd255;
        sleepiness = 8'd0;
        handshake();
        sleepReq = 1'b1;
        tick();
        sleepReq = 1'b0;
        check("t4_manual_sleep", doSleep, 1'b1);
        check("t4_manual_noeat", doEat,   1'b0);
        autoEn = 1'b0;
        handshake();
        tick();
        tick();
        check("t4_auto_off", busy,        1'b0);
        check("t4_count",    actionCount, 8'd3);

        // 5. reset in REQ_EAT with sleep pending
        do_reset();
        eatReq = 1'b1;
        tick();
        eatReq   = 1'b0;
        sleepReq = 1'b1;
        tick();
        sleepReq = 1'b0;
        reset    = 1'b1;
        tick();
        check("t5_doEat", doEat, 1'b0);
        check("t5_busy",  busy,  1'b0);
        reset = 1'b0;
        repeat (3) tick();
        check("t5_no_sleep", doSleep, 1'b0);
        check("t5_idle",     busy,    1'b0);

        // 6. saturation and stray done in IDLE
        do_reset();
        for (int i = 0; i < 256; i++) begin
            eatReq = 1'b1;
            tick();
            eatReq = 1'b0;
            handshake();
            if (i == 127) check("t6_count_128", actionCount, 8'd128);
        end
        check("t6_saturated", actionCount, 8'd255);
        done = 1'b1;
        tick();
        check("t6_stray_busy",  busy,        1'b0);
        check("t6_stray_count", actionCount, 8'd255);
        done = 1'b0;
        tick();
        check("t6_final_count", actionCount, 8'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/action_initiator.md
Name: action_initiator

Overview:
- Requester side of the home-action handshake. Turns one-cycle eat/sleep command pulses, plus optional automatic stat-driven requests, into level-held doEat/doSleep requests.
- Holds each request until the action block reports done, then releases it and waits for done to drop (4-phase handshake).
- Buffers one request that arrives while busy.
- Aborts a request that gets no done within a timeout.
- Sits between the keyboard/button command decoders and the home-actions block.

Parameters:
TIMEOUT, 300_000_000, cycles allowed in a request state before abort (must exceed action duration of 250_000_000)
THRESH, 8'd200, stat level at or above which auto mode issues a request
CNT_W, 8, width of completed-action counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
eatReq  input  1  one-cycle eat command pulse
sleepReq  input  1  one-cycle sleep command pulse
autoEn  input  1  enable stat-driven automatic requests
hunger  input  8  current hunger level (higher = hungrier)
sleepiness  input  8  current sleepiness level (higher = sleepier)
done  input  1  action block reports action complete
doEat  output  1  eat request level to action block
doSleep  output  1  sleep request level to action block
busy  output  1  high in any state other than IDLE
actionCount  output  CNT_W  completed actions, saturating
timeoutErr  output  1  one-cycle pulse on request abort

Behaviour:
- Reset (synchronous, active-high) applies on the next clk edge from any state.
  - State goes to IDLE; pending buffer and timeout counter clear.
  - doEat, doSleep, busy, actionCount and timeoutErr are all 0.
- States:
  - IDLE: no request asserted.
  - REQ_EAT: doEat=1.
  - REQ_SLEEP: doSleep=1.
  - RELEASE: both requests 0; waiting for done=0.
- doEat and doSleep are registered, decoded from state, and never high together.
- IDLE selects the next request in this priority order; the selected state is entered on the next edge:
  1. Pending buffer.
  2. eatReq.
  3. sleepReq.
  4. Auto mode: autoEn && hunger>=THRESH, then autoEn && sleepiness>=THRESH.
  - With no source active, stay in IDLE.
- Latency: a request pulse in IDLE gives doEat/doSleep=1 on the next cycle.
- REQ_x, done=1:
  - Go to RELEASE; the request drops on the next cycle.
  - actionCount increments on that edge; it saturates at 2^CNT_W-1.
- REQ_x timeout:
  - Counter clears on REQ entry and increments every cycle in REQ.
  - When it reaches TIMEOUT-1 with done=0, go to RELEASE and pulse timeoutErr for exactly one cycle.
  - actionCount is unchanged.
  - done=1 on the same cycle as the limit counts as completion, not a timeout.
- RELEASE: wait for done=0, then go to IDLE on the next edge. RELEASE is never left while done=1.
- Pending buffer (one entry, one-hot eat/sleep):
  - Captures eatReq/sleepReq arriving in any non-IDLE state.
  - Eat wins on a simultaneous capture.
  - A later capture overwrites an earlier one.
  - A request for the action currently in REQ_x is dropped, not buffered.
  - A simultaneous eatReq+sleepReq in IDLE issues eat and buffers sleep.
  - The buffer clears when its entry is issued from IDLE.
- Auto requests are never buffered; they are re-evaluated only in IDLE.
- Changes to hunger, sleepiness or autoEn during REQ or RELEASE have no effect on the request in flight.
- A done=1 seen in IDLE is ignored; no count change.

Test Plan:
(Bench params: TIMEOUT=20, THRESH=8'd200.)
1. Single eat: eatReq pulse at cycle 0 in IDLE -> doEat=1, busy=1 from cycle 1. Drive done=1 at cycle 8 -> doEat=0 at cycle 9, actionCount=1. done=0 at cycle 10 -> busy=0 at cycle 11.
2. Simultaneous eatReq+sleepReq in IDLE -> doEat asserts, doSleep never high while doEat is high. After the eat handshake completes and IDLE is reached -> doSleep=1 one cycle later. actionCount=2 after both complete.
3. Timeout: sleepReq, done held 0 -> doSleep drops after 20 cycles in REQ_SLEEP. timeoutErr=1 for exactly one cycle; actionCount unchanged; back to IDLE next cycle.
4. Auto mode:
   - autoEn=1, hunger=200, sleepiness=0 -> doEat.
   - hunger=199, sleepiness=250 -> doSleep.
   - hunger=255 with sleepReq pulse the same IDLE cycle -> doSleep (manual wins).
   - autoEn=0 with hunger=255 -> stays IDLE.
5. Reset mid-operation: reset=1 while in REQ_EAT with sleep pending -> next cycle all outputs 0. Releasing reset with no inputs -> stays IDLE; no sleep issued.
6. Saturation and stray done: perform 256 completed actions (CNT_W=8) -> actionCount holds 255. done pulse while in IDLE -> no state or count change.
